udma_clkdiv_req: RTL and testbench

//  Config-domain requester for the uDMA integer clock divider. Turns peripheral register writes of a

---
 rtl/udma_clkdiv_pkg.sv | 12 +
 rtl/udma_ack_sync.sv | 23 ++
 rtl/udma_clkdiv_req.sv | 158 +++++++++++++++
 tb/tb_udma_clkdiv_req.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_clkdiv_pkg.sv
// Shared types and defaults for the uDMA clock-divider request path.
package udma_clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } clkdiv_req_state_e;

  localparam int unsigned DIV_W_DEF = 8;

endpackage

// File: rtl/udma_ack_sync.sv
// Reset-to-0 multi-flop synchronizer bringing the divider's ack level into clk_i.
module udma_ack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic ack_i,
  output logic ack_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/udma_clkdiv_req.sv
// Config-domain 4-phase requester for the uDMA clock divider.
// Optional per-phase timeout with sticky error enabled by UDMA_CLKDIV_TIMEOUT_EN.
module udma_clkdiv_req
  import udma_clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W          = DIV_W_DEF,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_we_i,
  output logic [DIV_W-1:0] cfg_div_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [DIV_W-1:0] clk_div_data_o,
  output logic             clk_div_valid_o,
  input  logic             clk_div_ack_i
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : gen_param_err
    $error("udma_clkdiv_req: SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
  end

  clkdiv_req_state_e state_q, state_d;
  logic [DIV_W-1:0]  data_q, data_d;
  logic [DIV_W-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0]  commit_q, commit_d;
  logic              valid_q, busy_q, done_q, done_d;
  logic              ack_s;
  logic              phase_tmo;

  udma_ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .ack_i  (clk_div_ack_i),
    .ack_s_o(ack_s)
  );

`ifdef UDMA_CLKDIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign phase_tmo = (state_q != IDLE) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every phase entry so REQ and REL each get a full budget.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q || state_q == IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (phase_tmo && state_q == REL && ack_s) begin
        err_q <= 1'b1;
      end else if (cfg_we_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign phase_tmo = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    commit_d   = commit_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_we_i) begin
          data_d  = cfg_div_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cfg_we_i) begin
          pend_d     = cfg_div_i;
          pend_vld_d = 1'b1;
        end
        if (ack_s || phase_tmo) begin
          state_d = REL;
        end
      end
      REL: begin
        if (cfg_we_i) begin
          pend_d     = cfg_div_i;
          pend_vld_d = 1'b1;
        end
        if (!ack_s) begin
          done_d   = 1'b1;
          commit_d = data_q;
          // A write landing on the exit cycle is newer than anything pending.
          if (cfg_we_i) begin
            data_d     = cfg_div_i;
            pend_vld_d = 1'b0;
            state_d    = REQ;
          end else if (pend_vld_q) begin
            data_d     = pend_q;
            pend_vld_d = 1'b0;
            state_d    = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (phase_tmo) begin
          pend_vld_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      data_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      commit_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      commit_q   <= commit_d;
      valid_q    <= (state_d == REQ);
      busy_q     <= (state_d != IDLE) | pend_vld_d;
      done_q     <= done_d;
    end
  end

  assign clk_div_valid_o = valid_q;
  assign clk_div_data_o  = data_q;
  assign cfg_div_o       = commit_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_udma_clkdiv_req.sv
// Directed bench for udma_clkdiv_req with a delayed-ack divider model.
module tb_udma_clkdiv_req;
  import udma_clkdiv_pkg::*;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] cfg_div_i = 8'h00;
  logic       cfg_we_i = 1'b0;
  logic [7:0] cfg_div_o;
  logic       busy_o, done_o, err_o;
  logic [7:0] clk_div_data_o;
  logic       clk_div_valid_o;
  logic       clk_div_ack_i = 1'b0;

  logic       ack_force = 1'b0;
  logic       ack_val = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  logic [7:0] presented[$];

  always #5 clk_i = ~clk_i;

  udma_clkdiv_req #(
    .DIV_W         (8),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cfg_div_i      (cfg_div_i),
    .cfg_we_i       (cfg_we_i),
    .cfg_div_o      (cfg_div_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .clk_div_data_o (clk_div_data_o),
    .clk_div_valid_o(clk_div_valid_o),
    .clk_div_ack_i  (clk_div_ack_i)
  );

  // Divider-side model: ack follows valid after 2-20 cycles, or is forced.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (ack_force) begin
        clk_div_ack_i = ack_val;
      end else if (clk_div_valid_o !== clk_div_ack_i) begin
        repeat ($urandom_range(20, 2) - 1) @(posedge clk_i);
        #2;
        if (!ack_force) clk_div_ack_i = clk_div_valid_o;
      end
    end
  end

  // Data may only move while the request is low and ack_s is low.
  logic [7:0] prev_data = 8'h00;
  logic       prev_valid = 1'b0, prev_acks = 1'b0, prev_rstn = 1'b0;
  always @(negedge clk_i) begin
    if (rstn_i && prev_rstn && clk_div_data_o !== prev_data) begin
      vectors++;
      assert (prev_valid === 1'b0 && prev_acks === 1'b0) else begin
        miscompares++;
        $error("FAIL data_stable: observed valid=%b ack_s=%b at change, expected 0/0",
               prev_valid, prev_acks);
      end
    end
    if (clk_div_valid_o && !prev_valid) presented.push_back(clk_div_data_o);
    if (done_o) done_cnt++;
    prev_data  = clk_div_data_o;
    prev_valid = clk_div_valid_o;
    prev_acks  = dut.ack_s;
    prev_rstn  = rstn_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write is taken.
  task automatic write(input logic [7:0] v);
    cfg_div_i = v;
    cfg_we_i  = 1'b1;
    @(negedge clk_i);
    cfg_we_i  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (done_o) break;
      @(negedge clk_i);
    end
    chk(tag, done_o, 1);
  endtask

  initial begin
    logic [15:0] pres_pair;
    int          done_before;

    // T1 reset
    #1;
    chk("rst_valid", clk_div_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cfg", cfg_div_o, 0);
    chk("rst_data", clk_div_data_o, 0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("idle_valid", clk_div_valid_o, 0);
    chk("idle_busy", busy_o, 0);

    // T2 single write
    write(8'h05);
    chk("t2_valid", clk_div_valid_o, 1);
    chk("t2_data", clk_div_data_o, 8'h05);
    chk("t2_busy", busy_o, 1);
    wait_done("t2_done");
    chk("t2_cfg", cfg_div_o, 8'h05);
    chk("t2_busy_end", busy_o, 0);
    @(negedge clk_i);
    chk("t2_done_pulse", done_o, 0);

    // T3 queued writes, last wins
    presented.delete();
    write(8'h03);
    cfg_div_i = 8'h07;
    cfg_we_i  = 1'b1;
    @(negedge clk_i);
    cfg_div_i = 8'h09;
    @(negedge clk_i);
    cfg_we_i  = 1'b0;
    chk("t3_valid", clk_div_valid_o, 1);
    chk("t3_data", clk_div_data_o, 8'h03);
    wait_done("t3_done1");
    chk("t3_cfg1", cfg_div_o, 8'h03);
    chk("t3_busy1", busy_o, 1);
    chk("t3_valid2", clk_div_valid_o, 1);
    chk("t3_data2", clk_div_data_o, 8'h09);
    @(negedge clk_i);
    wait_done("t3_done2");
    chk("t3_cfg2", cfg_div_o, 8'h09);
    chk("t3_busy2", busy_o, 0);
    chk("t3_count", presented.size(), 2);
    pres_pair = 16'hffff;
    if (presented.size() == 2) pres_pair = {presented[0], presented[1]};
    chk("t3_seq", pres_pair, 16'h0309);

    // T4 write on the REL exit cycle
    @(negedge clk_i);
    write(8'h0B);
    for (int i = 0; i < 200; i++) begin
      if (dut.state_q == REL && !dut.ack_s) break;
      @(negedge clk_i);
    end
    chk("t4_rel_exit", (dut.state_q == REL && !dut.ack_s), 1);
    write(8'h0A);
    chk("t4_done", done_o, 1);
    chk("t4_cfg", cfg_div_o, 8'h0B);
    chk("t4_valid", clk_div_valid_o, 1);
    chk("t4_data", clk_div_data_o, 8'h0A);
    chk("t4_busy", busy_o, 1);
    @(negedge clk_i);
    wait_done("t4_done2");
    chk("t4_cfg2", cfg_div_o, 8'h0A);

    // T5 bypass, then an identical write is still issued
    @(negedge clk_i);
    write(8'h00);
    chk("t5_valid", clk_div_valid_o, 1);
    chk("t5_data", clk_div_data_o, 8'h00);
    wait_done("t5_done");
    chk("t5_cfg", cfg_div_o, 8'h00);
    chk("t5_data_end", clk_div_data_o, 8'h00);
    @(negedge clk_i);
    write(8'h00);
    chk("t5_reissue", clk_div_valid_o, 1);
    wait_done("t5_done2");
    chk("t5_err", err_o, 0);

    // Reset mid-handshake drops valid at once
    @(negedge clk_i);
    write(8'h04);
    chk("rst_mid_valid1", clk_div_valid_o, 1);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_valid0", clk_div_valid_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_data", clk_div_data_o, 8'h00);
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!clk_div_ack_i) break;
      @(negedge clk_i);
    end
    chk("rst_mid_ack_low", clk_div_ack_i, 0);
    repeat (5) @(negedge clk_i);

`ifdef UDMA_CLKDIV_TIMEOUT_EN
    // T6a ack stuck low: REQ forced to REL after 16 cycles
    ack_force = 1'b1;
    ack_val   = 1'b0;
    repeat (2) @(negedge clk_i);
    write(8'h06);
    repeat (15) @(negedge clk_i);
    chk("t6_valid_hold", clk_div_valid_o, 1);
    @(negedge clk_i);
    chk("t6_valid_drop", clk_div_valid_o, 0);
    repeat (3) @(negedge clk_i);
    chk("t6_idle", busy_o, 0);

    // T6b ack stuck high: REL times out, sticky error
    ack_val = 1'b1;
    repeat (4) @(negedge clk_i);
    done_before = done_cnt;
    write(8'h0C);
    for (int i = 0; i < 100; i++) begin
      if (err_o) break;
      @(negedge clk_i);
    end
    chk("t6_err", err_o, 1);
    chk("t6_busy", busy_o, 0);
    chk("t6_cfg_keep", cfg_div_o, 8'h06);
    chk("t6_no_done", done_cnt - done_before, 0);
    ack_val = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("t6_err_sticky", err_o, 1);
    write(8'h0D);
    chk("t6_err_clr", err_o, 0);
    ack_force = 1'b0;
    wait_done("t6_done");
    chk("t6_cfg", cfg_div_o, 8'h0D);
`endif

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

endmodule
